nes_poller: RTL
===============

NES_POLLER -- requirements
Module: nes_poller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 600, meaning clk cycles per NES half-bit phase (6 us at 100 MHz); legal range >= 3.
REQ-002 SHALL have parameter POLL_CYCLES, default 1666666, meaning clk cycles between frame starts (60 Hz); legal when > 18*HALF_PERIOD + 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  high permits new frames to start.
REQ-006 SHALL have port nes_data  input  1  controller serial data; asynchronous; active-low button level.
REQ-007 SHALL have port nes_latch  output  1  controller latch strobe.
REQ-008 SHALL have port nes_clk  output  1  controller shift clock.
REQ-009 SHALL have port buttons  output  8  active-high button state: [0] A, [1] B, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right.
REQ-010 SHALL have port buttons_valid  output  1  one-cycle pulse when buttons is updated.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress (any state but IDLE).

Function
REQ-012 SHALL pass nes_data through a two-flop synchroniser; all sampling uses the synchronised value.
REQ-013 SHALL run a free-running poll counter 0..POLL_CYCLES-1 that wraps to 0 and counts regardless of enable or FSM state.
REQ-014 SHALL use FSM states IDLE, LATCH, LOW, HIGH, DONE, with a phase counter and a 3-bit bit index.
REQ-015 SHALL leave IDLE for LATCH only in the cycle where the poll counter = POLL_CYCLES-1, enable = 1 and the state is IDLE.
REQ-016 SHALL start no frame if enable is low in the trigger cycle, with no deferred start.
REQ-017 SHALL not abort a frame already in progress when enable drops.
REQ-018 SHALL drive nes_latch high for exactly 2*HALF_PERIOD cycles in LATCH, then enter LOW with bit index 0.
REQ-019 SHALL hold nes_clk low for HALF_PERIOD cycles in LOW and capture the synchronised bit into shift position [bit index] on the last LOW cycle.
REQ-020 SHALL drive nes_clk high for HALF_PERIOD cycles in HIGH, after every bit including bit 7.
REQ-021 SHALL leave HIGH for LOW with bit index +1 if bit index < 7, else for DONE.
REQ-022 SHALL in DONE, for exactly one cycle, load buttons[i] = NOT captured bit i, assert buttons_valid, then return to IDLE.
REQ-023 SHALL drive nes_latch and nes_clk from registers and hold both low in IDLE and DONE.
REQ-024 SHALL have a frame length, from the first nes_latch-high cycle to the buttons_valid cycle, of 18*HALF_PERIOD + 1 cycles.
REQ-025 SHALL hold buttons unchanged between DONE cycles, so a partial frame never alters it.
REQ-026 SHALL report buttons = 8'h00 when the controller is absent (nes_data held high).

Reset
REQ-027 SHALL, while reset is high at a clk edge, set the state to IDLE, the poll counter, phase counter and bit index to 0, the shift register to 0, nes_latch = 0, nes_clk = 0, buttons = 8'h00, buttons_valid = 0 and busy = 0.
REQ-028 SHALL, when reset is asserted mid-frame, abandon the frame in that cycle without producing a buttons_valid pulse and leave buttons = 8'h00.
REQ-029 SHALL take precedence over all other inputs while reset is high.

Verification (HALF_PERIOD=4, POLL_CYCLES=100 unless stated)
REQ-030 SHALL cover a basic frame: after reset, enable=1, controller model drives A and Up pressed (bits 0 and 4 low) -> nes_latch high for 8 cycles, 8 nes_clk high pulses each 4 cycles wide, buttons = 8'h11 with a single buttons_valid pulse 73 cycles after nes_latch rises.
REQ-031 SHALL cover an absent controller: nes_data tied 1 -> every frame ends with buttons = 8'h00 and buttons_valid pulsing once per 100 cycles.
REQ-032 SHALL cover enable gating: enable=0 in the trigger cycle -> no nes_latch and busy stays 0 for that period; enable drop mid-frame -> the frame completes and buttons updates.
REQ-033 SHALL cover mid-frame reset: reset asserted during the LOW phase of bit 3 -> next cycle nes_latch=0, nes_clk=0, busy=0, buttons=8'h00, no buttons_valid.
REQ-034 SHALL cover changing data: model presses all buttons on frame 1 and only Right on frame 2 -> buttons 8'hFF then 8'h80, each aligned with buttons_valid.
REQ-035 SHALL cover the default parameters: one frame -> nes_latch width 1200 cycles and buttons_valid period 1666666 cycles.

Source files
------------

// File: rtl/nes_poller.sv
// NES controller poller: periodically latches the pad, clocks out eight serial
// bits and publishes the active-high button state with a one-cycle valid pulse.
module nes_poller #(
  parameter int unsigned HALF_PERIOD = 600,
  parameter int unsigned POLL_CYCLES = 1666666
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int unsigned PW = $clog2(2 * HALF_PERIOD);
  localparam int unsigned CW = $clog2(POLL_CYCLES);
  localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase_next;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_next;
  logic [CW-1:0] r_poll;
  logic [7:0]    r_shift;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_latch;
  logic          r_nclk;
  logic [7:0]    r_buttons;
  logic          r_valid;
  logic          w_trigger;
  logic          w_capture;
  logic          w_latch_next;
  logic          w_nclk_next;
  logic          w_valid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= nes_data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || r_poll == POLL_LAST) r_poll <= '0;
    else                              r_poll <= r_poll + CW'(1);
  end

  assign w_trigger = (r_poll == POLL_LAST) && enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      r_phase <= w_phase_next;
      r_bit   <= w_bit_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_bit_next   = r_bit;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_next = S_LATCH;
          w_phase_next = '0;
        end
      end
      S_LATCH: begin
        if (r_phase == LATCH_LAST) begin
          w_state_next = S_LOW;
          w_phase_next = '0;
          w_bit_next   = '0;
        end else begin
          w_phase_next = r_phase + PW'(1);
        end
      end
      S_LOW: begin
        if (r_phase == HALF_LAST) begin
          w_state_next = S_HIGH;
          w_phase_next = '0;
          w_capture    = 1'b1;
        end else begin
          w_phase_next = r_phase + PW'(1);
        end
      end
      S_HIGH: begin
        if (r_phase == HALF_LAST) begin
          w_phase_next = '0;
          if (r_bit == 3'd7) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_LOW;
            w_bit_next   = r_bit + 3'd1;
          end
        end else begin
          w_phase_next = r_phase + PW'(1);
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered pins line up
  // exactly with the state they belong to.
  always_comb begin
    w_latch_next = (w_state_next == S_LATCH);
    w_nclk_next  = (w_state_next == S_HIGH);
    w_valid_next = (w_state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_latch   <= 1'b0;
      r_nclk    <= 1'b0;
      r_buttons <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_capture) r_shift[r_bit] <= r_sync2;
      r_latch <= w_latch_next;
      r_nclk  <= w_nclk_next;
      r_valid <= w_valid_next;
      if (w_valid_next) r_buttons <= ~r_shift;
    end
  end

  assign nes_latch     = r_latch;
  assign nes_clk       = r_nclk;
  assign buttons       = r_buttons;
  assign buttons_valid = r_valid;
  assign busy          = (r_state != S_IDLE);

endmodule
